// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment display arbiter
package seg_pkg;
  typedef enum logic [1:0] {IDLE, CONV, PUB} state_t;
  localparam int NDIGITS = 8;
  localparam int NIB = 4;
  localparam logic [7:0] BLANK_RST = 8'hFE;
  localparam logic [7:0] BLANK_HEX = 8'hC0;
  function automatic logic [NDIGITS-1:0] lz_mask(input logic [NDIGITS*NIB-1:0] bcd);
    logic z;
    lz_mask = '0;
    z = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      z = z & (bcd[i*NIB +: NIB] == '0);
      lz_mask[i] = z;
    end
  endfunction
endpackage

// File: rtl/seg_disp_arbiter_dabble_step.sv
// dabble_step: one double-dabble iteration, add-3 on every nibble >= 5 then shift in one bit
module dabble_step
  import seg_pkg::*;
(
  input  logic [NDIGITS*NIB-1:0] bcd_i,
  input  logic                   bit_i,
  output logic [NDIGITS*NIB-1:0] bcd_o
);
  logic [NDIGITS*NIB-1:0] adj;
  for (genvar i = 0; i < NDIGITS; i++) begin : g_nib
    assign adj[i*NIB +: NIB] = (bcd_i[i*NIB +: NIB] >= 4'd5) ? bcd_i[i*NIB +: NIB] + 4'd3 : bcd_i[i*NIB +: NIB];
  end
  assign bcd_o = (adj << 1) | (NDIGITS*NIB)'(bit_i);
endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: arbitrates CPU/switch display requests and converts the winner to display digits
module seg_disp_arbiter
  import seg_pkg::*;
#(
  parameter int DW          = 24,
  parameter int HOLD_CYCLES = 200000000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [DW-1:0] cpu_data,
  input  logic          cpu_dec,
  output logic          cpu_ack,
  input  logic          sw_req,
  input  logic [DW-1:0] sw_data,
  output logic          sw_ack,
  output logic [31:0]   digits,
  output logic [7:0]    blank,
  output logic          upd,
  output logic          busy,
  output logic          cpu_owner
);
  localparam int BW = NDIGITS * NIB;
  localparam int CW = $clog2(DW + 1);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  if (DW > 26) begin : g_dw_check
    $error("seg_disp_arbiter: DW above 26 overflows 8 BCD digits");
  end
  state_t state_q, state_d;
  logic [DW-1:0] shift_q, shift_d, gdata;
  logic [BW-1:0] bcd_q, bcd_d, bcd_step, digits_q, digits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0] blank_q, blank_d;
  logic dec_q, dec_d, upd_q, upd_d, cpu_ack_q, cpu_ack_d, sw_ack_q, sw_ack_d;
  logic cpu_go, sw_go, gdec;
  dabble_step u_step (
    .bcd_i(bcd_q),
    .bit_i(shift_q[DW-1]),
    .bcd_o(bcd_step)
  );
  // arbitration, hold window, conversion stepping and publish
  always_comb begin
    cpu_go = (state_q == IDLE) && cpu_req;
    sw_go = (state_q == IDLE) && !cpu_req && sw_req && (hold_q == '0);
    gdata = cpu_go ? cpu_data : sw_data;
    gdec = cpu_go ? cpu_dec : 1'b1;
    state_d = state_q;
    shift_d = shift_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    dec_d = dec_q;
    digits_d = digits_q;
    blank_d = blank_q;
    upd_d = (state_q == PUB);
    cpu_ack_d = cpu_go;
    sw_ack_d = sw_go;
    hold_d = cpu_go ? HW'(HOLD_CYCLES) : (hold_q == '0 ? hold_q : hold_q - 1'b1);
    if (cpu_go || sw_go) begin
      dec_d = gdec;
      shift_d = gdata;
      cnt_d = '0;
      bcd_d = gdec ? '0 : BW'(gdata);
      state_d = gdec ? CONV : PUB;
    end else if (state_q == CONV) begin
      bcd_d = bcd_step;
      shift_d = shift_q << 1;
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(DW - 1)) ? PUB : CONV;
    end else if (state_q == PUB) begin
      digits_d = bcd_q;
      blank_d = !dec_q ? BLANK_HEX : (LZ_BLANK ? lz_mask(bcd_q) : 8'h00);
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      dec_q <= 1'b0;
      hold_q <= '0;
      digits_q <= '0;
      blank_q <= BLANK_RST;
      upd_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      sw_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      dec_q <= dec_d;
      hold_q <= hold_d;
      digits_q <= digits_d;
      blank_q <= blank_d;
      upd_q <= upd_d;
      cpu_ack_q <= cpu_ack_d;
      sw_ack_q <= sw_ack_d;
    end
  end
  assign digits = digits_q;
  assign blank = blank_q;
  assign upd = upd_q;
  assign cpu_ack = cpu_ack_q;
  assign sw_ack = sw_ack_q;
  assign busy = (state_q != IDLE);
  assign cpu_owner = (hold_q != '0);
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: table-driven, directed and random checks of seg_disp_arbiter
module tb_seg_disp_arbiter;
  localparam int DW = 24;
  localparam int HOLD = 50;
  logic clk = 1'b0, rst = 1'b1, cpu_req = 1'b0, cpu_dec = 1'b0, sw_req = 1'b0;
  logic [DW-1:0] cpu_data = '0, sw_data = '0;
  logic cpu_ack, sw_ack, upd, busy, cpu_owner;
  logic cpu_ack0, sw_ack0, upd0, busy0, cpu_owner0;
  logic [31:0] digits, digits0;
  logic [7:0] blank, blank0;
  int cyc = 0, n_chk = 0, n_fail = 0, last_cpu = -1000;
  typedef struct {
    logic        is_cpu;
    logic [23:0] data;
    logic        dec;
    logic [31:0] exp_d;
    logic [7:0]  exp_b1;
    logic [7:0]  exp_b0;
  } vec_t;
  vec_t tbl[6];

  seg_disp_arbiter #(.DW(DW), .HOLD_CYCLES(HOLD), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_dec(cpu_dec),
    .cpu_ack(cpu_ack), .sw_req(sw_req), .sw_data(sw_data), .sw_ack(sw_ack),
    .digits(digits), .blank(blank), .upd(upd), .busy(busy), .cpu_owner(cpu_owner)
  );
  seg_disp_arbiter #(.DW(DW), .HOLD_CYCLES(HOLD), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_dec(cpu_dec),
    .cpu_ack(cpu_ack0), .sw_req(sw_req), .sw_data(sw_data), .sw_ack(sw_ack0),
    .digits(digits0), .blank(blank0), .upd(upd0), .busy(busy0), .cpu_owner(cpu_owner0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_digits(input logic [23:0] d, input logic dec);
    int unsigned v;
    logic [31:0] r;
    if (!dec) return {8'h00, d};
    v = d;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] m_blank(input logic [31:0] dg, input logic dec, input logic lz);
    int h;
    logic [15:0] t;
    if (!dec) return 8'hC0;
    if (!lz) return 8'h00;
    h = 0;
    for (int i = 0; i < 8; i++) if (dg[i*4 +: 4] != 4'h0) h = i;
    t = 16'h00FF << (h + 1);
    return t[7:0];
  endfunction

  task automatic wait_ack(input logic is_cpu, output int e);
    e = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (is_cpu ? cpu_ack : sw_ack) begin
        e = cyc;
        break;
      end
    end
    check("ack seen", 32'(e >= 0), 32'd1);
    check("lz0 ack", is_cpu ? cpu_ack0 : sw_ack0, 32'd1);
    check("other ack", is_cpu ? sw_ack : cpu_ack, 32'd0);
  endtask

  task automatic wait_upd(input int g, input logic dec, input logic [31:0] ed,
                          input logic [7:0] eb1, input logic [7:0] eb0, output int u);
    u = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (upd) begin
        u = cyc;
        break;
      end
    end
    check("upd latency", 32'(u - g), dec ? 32'(DW + 1) : 32'd1);
    check("digits", digits, ed);
    check("blank", blank, 32'(eb1));
    check("lz0 upd", upd0, 32'd1);
    check("lz0 digits", digits0, ed);
    check("lz0 blank", blank0, 32'(eb0));
  endtask

  task automatic xact(input logic is_cpu, input logic [23:0] d, input logic dec,
                      input logic [31:0] ed, input logic [7:0] eb1, input logic [7:0] eb0);
    int ge, e, u;
    ge = is_cpu ? cyc + 1 : ((cyc + 1 > last_cpu + HOLD + 1) ? cyc + 1 : last_cpu + HOLD + 1);
    if (is_cpu) begin
      cpu_req = 1'b1;
      cpu_data = d;
      cpu_dec = dec;
    end else begin
      sw_req = 1'b1;
      sw_data = d;
    end
    wait_ack(is_cpu, e);
    if (is_cpu) cpu_req = 1'b0;
    else sw_req = 1'b0;
    check("grant edge", 32'(e), 32'(ge));
    check("cpu_owner at grant", cpu_owner, 32'(is_cpu));
    if (is_cpu) last_cpu = e;
    wait_upd(e, dec, ed, eb1, eb0, u);
    @(posedge clk);
    #1;
    check("upd pulse", upd, 32'd0);
    check("idle after pub", busy, 32'd0);
  endtask

  initial begin
    int e, e2, u, n;
    logic ic, dc;
    logic [23:0] d;
    logic [31:0] ed;
    tbl[0] = '{1'b1, 24'd1234,     1'b1, 32'h00001234, 8'hF0, 8'h00};
    tbl[1] = '{1'b1, 24'd16777215, 1'b1, 32'h16777215, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 24'd0,        1'b1, 32'h00000000, 8'hFE, 8'h00};
    tbl[3] = '{1'b1, 24'hABCDEF,   1'b0, 32'h00ABCDEF, 8'hC0, 8'hC0};
    tbl[4] = '{1'b0, 24'd999,      1'b1, 32'h00000999, 8'hF8, 8'h00};
    tbl[5] = '{1'b0, 24'd42,       1'b1, 32'h00000042, 8'hFC, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    check("rst digits", digits, 32'h0);
    check("rst blank", blank, 32'hFE);
    check("rst upd", upd, 32'd0);
    check("rst busy", busy, 32'd0);
    check("rst cpu_owner", cpu_owner, 32'd0);
    check("rst acks", {cpu_ack, sw_ack}, 32'd0);
    check("rst lz0 blank", blank0, 32'hFE);
    check("rst lz0 busy/owner", {busy0, cpu_owner0}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      xact(tbl[i].is_cpu, tbl[i].data, tbl[i].dec, tbl[i].exp_d, tbl[i].exp_b1, tbl[i].exp_b0);
    // both requesters high: CPU wins, switch waits out the hold window
    sw_req = 1'b1;
    sw_data = 24'd777;
    xact(1'b1, 24'd5, 1'b1, 32'h00000005, 8'hFE, 8'h00);
    xact(1'b0, 24'd777, 1'b1, 32'h00000777, 8'hF8, 8'h00);
    // CPU request raised while the switch value converts is granted on the first IDLE edge
    sw_req = 1'b1;
    sw_data = 24'd999;
    wait_ack(1'b0, e);
    sw_req = 1'b0;
    cpu_req = 1'b1;
    cpu_data = 24'd4321;
    cpu_dec = 1'b1;
    wait_upd(e, 1'b1, 32'h00000999, 8'hF8, 8'h00, u);
    wait_ack(1'b1, e2);
    cpu_req = 1'b0;
    check("grant after busy", 32'(e2), 32'(u + 1));
    last_cpu = e2;
    wait_upd(e2, 1'b1, 32'h00004321, 8'hF0, 8'h00, u);
    // reset in the middle of a conversion
    cpu_req = 1'b1;
    cpu_data = 24'd1234;
    cpu_dec = 1'b1;
    wait_ack(1'b1, e);
    cpu_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_cpu = -1000;
    check("midrst digits", digits, 32'h0);
    check("midrst blank", blank, 32'hFE);
    check("midrst busy", busy, 32'd0);
    check("midrst upd", upd, 32'd0);
    check("midrst cpu_owner", cpu_owner, 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      n += int'(upd);
    end
    check("no upd after reset", 32'(n), 32'd0);
    xact(1'b1, 24'd42, 1'b1, 32'h00000042, 8'hFC, 8'h00);
    // random traffic against the arithmetic reference model
    for (int i = 0; i < 30; i++) begin
      ic = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = 24'd0;
        1: d = 24'hFFFFFF;
        default: d = 24'($urandom);
      endcase
      dc = ic ? 1'($urandom_range(0, 1)) : 1'b1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      ed = m_digits(d, dc);
      xact(ic, d, dc, ed, m_blank(ed, dc, 1'b1), m_blank(ed, dc, 1'b0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
